// File: rtl/tlc_pkg.sv
// Shared encodings for the intersection phase scheduler:
// light codes, phase states and service selector.
package tlc_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [2:0] {
    HG   = 3'd0,
    HY   = 3'd1,
    AR1  = 3'd2,
    CG   = 3'd3,
    CY   = 3'd4,
    AR2  = 3'd5,
    WALK = 3'd6
  } state_e;

  typedef enum logic {
    CTRY = 1'b0,
    PED  = 1'b1
  } svc_e;

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Sensor inputs and lamp outputs of the intersection
// scheduler, grouped as one bundle.
interface intersection_phase_scheduler_if;

  logic       car_on_country_road;
  logic       ped_request;
  logic [1:0] highway_road;
  logic [1:0] country_road;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    output car_on_country_road,
    output ped_request,
    input  highway_road,
    input  country_road,
    input  walk,
    input  ped_pending,
    input  phase
  );

  modport slave (
    input  car_on_country_road,
    input  ped_request,
    output highway_road,
    output country_road,
    output walk,
    output ped_pending,
    output phase
  );

endinterface

// File: rtl/phase_timer.sv
// Cycles-in-phase counter: zeroed on a phase change,
// otherwise counts up and sticks at all-ones.
module phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               zero,
  output logic [TIMER_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (zero) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Highway/country/pedestrian phase sequencer with
// round-robin service after a highway minimum green.
module intersection_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 10,
  parameter int YELLOW_TIME = 3,
  parameter int CLEAR_TIME  = 2,
  parameter int WALK_TIME   = 6,
  parameter int TIMER_W     = 8
) (
  input logic clk,
  input logic clear,
  intersection_phase_scheduler_if.slave bus
);

  localparam logic [TIMER_W-1:0] T_MIN =
    TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] T_MAX =
    TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] T_YEL =
    TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] T_CLR =
    TIMER_W'(CLEAR_TIME - 1);
  localparam logic [TIMER_W-1:0] T_WLK =
    TIMER_W'(WALK_TIME - 1);

  state_e             state_q, state_d;
  svc_e               svc_q, svc_d;
  svc_e               last_q, last_d;
  logic               pend_q, pend_d;
  logic [TIMER_W-1:0] tmr;
  logic               car;
  logic               change;

  assign car    = bus.car_on_country_road;
  assign change = (state_d != state_q);

  phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst_n (clear),
    .zero  (change),
    .count (tmr)
  );

  always_comb begin
    state_d = state_q;
    svc_d   = svc_q;
    case (state_q)
      HG: begin
        if (tmr >= T_MIN && (car || pend_q)) begin
          state_d = HY;
          if (car && pend_q) begin
            svc_d = (last_q == CTRY) ? PED : CTRY;
          end else if (car) begin
            svc_d = CTRY;
          end else begin
            svc_d = PED;
          end
        end
      end
      HY:   if (tmr == T_YEL) state_d = AR1;
      AR1: begin
        if (tmr == T_CLR) begin
          state_d = (svc_q == CTRY) ? CG : WALK;
        end
      end
      CG: begin
        if (!car || tmr == T_MAX) state_d = CY;
      end
      CY:   if (tmr == T_YEL) state_d = AR2;
      WALK: if (tmr == T_WLK) state_d = AR2;
      AR2:  if (tmr == T_CLR) state_d = HG;
      default: state_d = HG;
    endcase
  end

  // Entering WALK both records service and drops the
  // latch, so a press on that same cycle is lost.
  always_comb begin
    last_d = last_q;
    pend_d = pend_q;
    if (change && state_d == CG) last_d = CTRY;
    if (change && state_d == WALK) begin
      last_d = PED;
      pend_d = 1'b0;
    end else if (bus.ped_request && state_q != WALK) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= HG;
      svc_q   <= CTRY;
      last_q  <= PED;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      svc_q   <= svc_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    bus.highway_road = RED;
    bus.country_road = RED;
    bus.walk         = 1'b0;
    case (state_q)
      HG:      bus.highway_road = GREEN;
      HY:      bus.highway_road = YELLOW;
      CG:      bus.country_road = GREEN;
      CY:      bus.country_road = YELLOW;
      WALK:    bus.walk         = 1'b1;
      default: ;
    endcase
  end

  assign bus.ped_pending = pend_q;
  assign bus.phase       = state_q;

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Sequences a highway/country-road intersection that also has a pedestrian crossing. It shares the green phase between two requesters: the country-road car sensor and a latched pedestrian push-button. Highway is the default phase. Requesters are served round-robin after a guaranteed highway minimum green. Drives the highway_road/country_road light codes plus a walk lamp.

Parameters:
MIN_GREEN, 5, minimum highway green in clk cycles (>=1)
MAX_GREEN, 10, maximum country green in clk cycles (>=1)
YELLOW_TIME, 3, yellow duration in cycles (>=1)
CLEAR_TIME, 2, all-red clearance duration in cycles (>=1)
WALK_TIME, 6, pedestrian walk duration in cycles (>=1)
TIMER_W, 8, phase timer width; must hold max(all durations)-1

Ports:
clk  in  1  system clock, rising edge
clear  in  1  asynchronous, active-low reset
car_on_country_road  in  1  level sensor, synchronous to clk
ped_request  in  1  push-button pulse (>=1 cycle), synchronous to clk
highway_road  out  2  highway light code
country_road  out  2  country light code
walk  out  1  pedestrian walk lamp
ped_pending  out  1  pedestrian request latched, not yet served
phase  out  3  current state encoding (debug)

Behaviour:
- Light codes: RED=2'b00, YELLOW=2'b01, GREEN=2'b10.
- Outputs are Moore, decoded from the state register only. There is no input-to-output combinational path.
- Reset (clear=0, asynchronous):
  - state=HG, timer=0, ped_pending=0, last_served=PED.
  - Outputs: highway=GREEN, country=RED, walk=0.
- Phase timer:
  - Zeroed on every state change.
  - Otherwise increments, saturating at all-ones.
  - "Expires(N)" means timer==N-1, so a timed state lasts exactly N cycles.
- States (highway/country/walk) and transitions:
  - HG (G/R/0): stays for at least MIN_GREEN cycles. Goes to HY when Expires(MIN_GREEN) or later AND (car_on_country_road OR ped_pending). With no request it stays indefinitely, timer saturated. On exit, latches svc:
    - only car -> CTRY
    - only ped -> PED
    - both -> the one not equal to last_served
  - HY (Y/R/0): YELLOW_TIME cycles -> AR1.
  - AR1 (R/R/0): CLEAR_TIME cycles -> CG if svc=CTRY, else WALK.
  - CG (R/G/0): goes to CY when car_on_country_road=0 OR Expires(MAX_GREEN). Minimum 1 cycle, even if the car left during HY/AR1. Sets last_served=CTRY on entry.
  - CY (R/Y/0): YELLOW_TIME cycles -> AR2.
  - WALK (R/R/1): WALK_TIME cycles -> AR2. ped_pending clears on entry. Sets last_served=PED on entry.
  - AR2 (R/R/0): CLEAR_TIME cycles -> HG. Every service returns through a full HG minimum green.
- ped_pending:
  - Set on any cycle with ped_request=1 while not in WALK.
  - Presses during WALK are ignored.
  - Pressing on the cycle of the AR1->WALK transition: the clear wins.
- phase encoding: HG=0, HY=1, AR1=2, CG=3, CY=4, AR2=5, WALK=6; 7 is unreachable.
- Illegal/unreachable state: returns to HG next cycle.
- Reset mid-operation: immediate return to reset values regardless of state. The pending request is lost.
- Never permitted: both roads non-RED; walk=1 while either road is non-RED.

Decomposition:
- Shared package/header tlc_pkg holds:
  - light-code constants RED/YELLOW/GREEN
  - state encodings
  - svc/last_served encoding (CTRY=0, PED=1)
- One sub-module, phase_timer (TIMER_W): synchronous zero on state-change strobe, saturating increment, async active-low clear.

Test Plan:
1. Reset, no requests for 50 cycles -> highway=GREEN, country=RED, walk=0, phase=0 throughout.
2. car_on_country_road=1 held from cycle 0 after reset release -> HG cycles 0-4, HY 5-7, AR1 8-9, CG 10-19 (MAX_GREEN cut-off), CY 20-22, AR2 23-24, HG from 25.
3. One-cycle ped_request at cycle 2, no car -> ped_pending=1 from cycle 3. HY at cycle 5, AR1 8-9, WALK 10-15 with walk=1 and both RED, ped_pending=0 from cycle 10, AR2 16-17, HG at 18.
4. Car held and ped pulse both at cycle 1 -> country served first (CG from cycle 10). After the car drops at cycle 12: CY at 13-15, AR2 16-17, HG 18-22, then HY, AR1, WALK starting cycle 28.
5. Car dropped at the second CG cycle -> CY on the next cycle; CG lasts exactly 2 cycles.
6. clear pulled low asynchronously mid-CY -> outputs become highway=GREEN, country=RED, walk=0, ped_pending=0 before the next clk edge. Phase resumes HG timing on release.
